// File: rtl/wb_chk_pkg.sv
// Shared types and default constants for the Wishbone register-write checker.
package wb_chk_pkg;

   localparam int unsigned TAG_W     = 16;
   localparam int unsigned ADDR_W    = 32;
   localparam int unsigned DLY_W     = 4;
   localparam int unsigned CNT_W_DEF = 8;

   localparam logic [TAG_W-1:0] START_TAG_DEF = 16'hAB60;
   localparam logic [TAG_W-1:0] PASS_TAG_DEF  = 16'hAB61;
   localparam logic [TAG_W-1:0] DONE_TAG_DEF  = 16'hAB62;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ARMED,
      ST_EVAL,
      ST_DONE
   } chk_state_e;

endpackage

// File: rtl/wb_reg_write_checker_if.sv
// Snooped Wishbone slave-write signals; the checker only ever observes them.
interface wb_reg_write_checker_if #(
   parameter int unsigned DATA_W = 32
);
   logic              cyc;
   logic              stb;
   logic              we;
   logic              ack;
   logic [31:0]       adr;
   logic [DATA_W-1:0] dat;

   modport master (output cyc, stb, we, ack, adr, dat);
   modport slave  (input  cyc, stb, we, ack, adr, dat);
endinterface

// File: rtl/wb_chk_channel.sv
// One checked register: address match, captured write data, delay counter, seen/err flags.
module wb_chk_channel
   import wb_chk_pkg::*;
#(
   parameter logic [ADDR_W-1:0] ADDR      = '0,
   parameter int unsigned       DATA_W    = 32,
   parameter int unsigned       CHK_DELAY = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] adr,
   output logic              match_c,
   input  logic              wr,
   input  logic [DATA_W-1:0] dat,
   input  logic [DATA_W-1:0] reg_val,
   input  logic              clear,
   output logic              pending,
   output logic              seen,
   output logic              err
);

   logic [DATA_W-1:0] cap;
   logic [DLY_W-1:0]  cnt;

   assign match_c = (adr == ADDR);

   // A new write always reloads, so an older pending compare is silently dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cap     <= '0;
         cnt     <= '0;
         pending <= 1'b0;
         seen    <= 1'b0;
         err     <= 1'b0;
      end else begin
         if (clear) begin
            seen <= 1'b0;
            err  <= 1'b0;
         end
         if (wr) begin
            cap     <= dat;
            cnt     <= DLY_W'(CHK_DELAY);
            pending <= 1'b1;
         end else if (clear) begin
            pending <= 1'b0;
         end else if (pending) begin
            if (cnt == '0) begin
               pending <= 1'b0;
               seen    <= 1'b1;
               if (reg_val != cap) err <= 1'b1;
            end else begin
               cnt <= cnt - DLY_W'(1);
            end
         end
      end
   end

endmodule

// File: rtl/wb_reg_write_checker.sv
// Snoops Wishbone writes to NUM_CH registers and checks the registers hold the written value.
// Optional watchdog enabled by defining CHK_TIMEOUT_EN.
module wb_reg_write_checker
   import wb_chk_pkg::*;
#(
   parameter int unsigned              NUM_CH      = 4,
   parameter int unsigned              DATA_W      = 32,
   parameter logic [NUM_CH*ADDR_W-1:0] CH_ADDRS    = {32'h3000001c, 32'h30000024,
                                                      32'h30000004, 32'h30000000},
   parameter int unsigned              CHK_DELAY   = 2,
   parameter int unsigned              CNT_W       = CNT_W_DEF,
   parameter logic [TAG_W-1:0]         START_TAG   = START_TAG_DEF,
   parameter logic [TAG_W-1:0]         PASS_TAG    = PASS_TAG_DEF,
   parameter logic [TAG_W-1:0]         DONE_TAG    = DONE_TAG_DEF,
   parameter int unsigned              TIMEOUT_CYC = 30000
) (
   input  logic                       wb_clk_i,
   input  logic                       wb_rst_n,
   wb_reg_write_checker_if.slave      wbs,
   input  logic [NUM_CH*DATA_W-1:0]   reg_val_i,
   input  logic [TAG_W-1:0]           tag_i,
   output logic [NUM_CH-1:0]          ch_seen_o,
   output logic [NUM_CH-1:0]          ch_err_o,
   output logic [CNT_W-1:0]           pass_cnt_o,
   output logic [CNT_W-1:0]           fail_cnt_o,
   output logic                       busy_o,
   output logic                       done_o,
   output logic                       timeout_o
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   chk_state_e        state;
   logic [TAG_W-1:0]  tag_q;
   logic              done_req;
   logic              start_ev_c, pass_ev_c, done_ev_c;
   logic              strobe_c, clear_c, wd_hit_c;
   logic [NUM_CH-1:0] match_c, wr_c, pending;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + CNT_W'(1);
   endfunction

   // Tag events fire only on the cycle the tag changes to a known value.
   assign start_ev_c = (tag_i != tag_q) && (tag_i == START_TAG);
   assign pass_ev_c  = (tag_i != tag_q) && (tag_i == PASS_TAG);
   assign done_ev_c  = (tag_i != tag_q) && (tag_i == DONE_TAG);

   assign strobe_c = wbs.cyc & wbs.stb & wbs.we & wbs.ack & (state == ST_ARMED);
   assign clear_c  = start_ev_c && ((state == ST_IDLE) || (state == ST_ARMED));

   // Lowest-numbered matching channel takes the write.
   always_comb begin
      logic hit;
      wr_c = '0;
      hit  = 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (match_c[k] && !hit) begin
            wr_c[k] = strobe_c;
            hit     = 1'b1;
         end
      end
   end

   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      wb_chk_channel #(
         .ADDR      (CH_ADDRS[k*ADDR_W +: ADDR_W]),
         .DATA_W    (DATA_W),
         .CHK_DELAY (CHK_DELAY)
      ) u_ch (
         .clk     (wb_clk_i),
         .rst_n   (wb_rst_n),
         .adr     (wbs.adr),
         .match_c (match_c[k]),
         .wr      (wr_c[k]),
         .dat     (wbs.dat),
         .reg_val (reg_val_i[k*DATA_W +: DATA_W]),
         .clear   (clear_c),
         .pending (pending[k]),
         .seen    (ch_seen_o[k]),
         .err     (ch_err_o[k])
      );
   end

`ifdef CHK_TIMEOUT_EN
   localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);
   logic [WD_W-1:0] wd_cnt;

   // Free-running watchdog from reset release; parks at the limit.
   always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
      if (!wb_rst_n)                                              wd_cnt <= '0;
      else if (state != ST_DONE && wd_cnt != WD_W'(TIMEOUT_CYC)) wd_cnt <= wd_cnt + WD_W'(1);
   end
   assign wd_hit_c = (wd_cnt == WD_W'(TIMEOUT_CYC)) && !done_ev_c;
`else
   assign wd_hit_c = 1'b0;
`endif

   always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         state      <= ST_IDLE;
         tag_q      <= '0;
         done_req   <= 1'b0;
         pass_cnt_o <= '0;
         fail_cnt_o <= '0;
         busy_o     <= 1'b0;
         done_o     <= 1'b0;
         timeout_o  <= 1'b0;
      end else begin
         tag_q <= tag_i;
         if (wd_hit_c && state != ST_DONE) begin
            timeout_o <= 1'b1;
            if (state == ST_ARMED || state == ST_EVAL) fail_cnt_o <= sat_inc(fail_cnt_o);
            state  <= ST_DONE;
            busy_o <= 1'b0;
            done_o <= 1'b1;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (start_ev_c) begin
                     state  <= ST_ARMED;
                     busy_o <= 1'b1;
                  end else if (done_ev_c) begin
                     state  <= ST_DONE;
                     done_o <= 1'b1;
                  end
               end
               ST_ARMED: begin
                  if (start_ev_c) begin
                     fail_cnt_o <= sat_inc(fail_cnt_o);
                  end else if (pass_ev_c) begin
                     state <= ST_EVAL;
                  end else if (done_ev_c) begin
                     state  <= ST_DONE;
                     busy_o <= 1'b0;
                     done_o <= 1'b1;
                  end
               end
               ST_EVAL: begin
                  if (done_ev_c) done_req <= 1'b1;
                  if (pending == '0) begin
                     if ((&ch_seen_o) && (ch_err_o == '0)) pass_cnt_o <= sat_inc(pass_cnt_o);
                     else                                  fail_cnt_o <= sat_inc(fail_cnt_o);
                     busy_o <= 1'b0;
                     if (done_req || done_ev_c) begin
                        state  <= ST_DONE;
                        done_o <= 1'b1;
                     end else begin
                        state <= ST_IDLE;
                     end
                  end
               end
               ST_DONE: ;
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: doc/wb_reg_write_checker.md
Name: wb_reg_write_checker

Overview:
- Synthesizable successor to the FPU min/max register-write monitor; sits in the user project area beside the FPU.
- Snoops Wishbone slave writes to NUM_CH register addresses and captures each written value.
- After a programmable delay, compares the captured value with the value the target register actually holds.
- Sequences tests from a 16-bit tag word (firmware checkbits) and reports pass/fail counts and per-channel error masks.

Parameters:
- NUM_CH, 4, number of checked register channels (1..8)
- DATA_W, 32, register/data width
- CH_ADDRS, {32'h3000001c,32'h30000024,32'h30000004,32'h30000000}, packed NUM_CH*32 address table; channel 0 = LSBs
- CHK_DELAY, 2, cycles from acked write to compare (1..15)
- CNT_W, 8, pass/fail counter width
- START_TAG / PASS_TAG / DONE_TAG, 16'hAB60 / 16'hAB61 / 16'hAB62, tag values
- TIMEOUT_CYC, 30000, watchdog limit; used only with CHK_TIMEOUT_EN

Ports:
- wb_clk_i  in  1  clock
- wb_rst_n  in  1  asynchronous active-low reset
- wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  snooped bus strobes
- wbs_ack_i  in  1  snooped slave ack
- wbs_adr_i  in  32  snooped address
- wbs_dat_i  in  DATA_W  snooped write data
- reg_val_i  in  NUM_CH*DATA_W  live target register values, channel 0 = LSBs
- tag_i  in  16  firmware test tag
- ch_seen_o  out  NUM_CH  channel written and compared in current test
- ch_err_o  out  NUM_CH  channel miscompared in current test (sticky per test)
- pass_cnt_o, fail_cnt_o  out  CNT_W  completed test counts
- busy_o  out  1  test in progress
- done_o  out  1  DONE_TAG seen; sticky
- timeout_o  out  1  watchdog expired (0 when feature absent)

Behaviour:
- Reset: all outputs 0; FSM IDLE; captures, delay counters and tag register cleared. Reset mid-test discards everything.
- Tag event: tag_q registers tag_i. An event fires only in the cycle where tag_i != tag_q and tag_i equals a tag value. A held tag fires once.
- Write strobe: cyc & stb & we & ack & (adr == CH_ADDRS[k]). On strobe, channel k captures wbs_dat_i and loads its counter with CHK_DELAY.
- Compare: counter reaches 0 -> compare reg_val_i[k] with the capture. Set ch_seen[k]; set ch_err[k] on mismatch.
- Same-channel write while its compare is pending: the new data replaces the old and the counter reloads (last write wins). No compare is issued for the old data.
- Address matching no channel: ignored. Duplicate addresses in CH_ADDRS: the lowest channel wins.
- FSM:
  - IDLE: START event -> ARMED; clear ch_seen/ch_err; busy_o=1.
  - ARMED: write strobes are processed. PASS event -> EVAL. DONE event -> DONE.
  - EVAL: hold until no compare is pending. Then pass if every ch_seen bit is 1 and every ch_err bit is 0; otherwise fail. Increment pass_cnt or fail_cnt, then -> IDLE with busy_o=0. ch_seen/ch_err hold their values until the next START.
  - DONE: done_o=1, busy_o=0, terminal until reset.
  - A START event in ARMED abandons the test: counted as fail, masks cleared, stays ARMED.
  - A DONE event in IDLE or EVAL: EVAL finishes its count first, then -> DONE.
  - Strobes in IDLE/DONE are ignored.
- Counters saturate at all-ones.
- Latency: ch_seen/ch_err update CHK_DELAY+1 cycles after the acked write. Counter update occurs at least 1 cycle after the PASS event.

Optional Feature:
- CHK_TIMEOUT_EN defined: a free-running counter starts at reset release. When it reaches TIMEOUT_CYC before a DONE event, set timeout_o (sticky), count one fail if ARMED/EVAL, and -> DONE.
- Undefined: no counter logic; timeout_o tied 0.

Decomposition:
- Package wb_chk_pkg: FSM state enum (IDLE, ARMED, EVAL, DONE), default tag constants, CNT_W default.
- One natural sub-module, wb_chk_channel, instantiated NUM_CH times: address match, capture register, delay counter, seen/err flags.

Test Plan:
- START, then writes a=3F800000, b=40000000, rm=0, op=0x1003 with reg_val_i matching, then PASS -> ch_seen=4'hF, ch_err=0, pass_cnt=1.
- Same sequence, but reg_val_i for b reads 0x40000001 at compare time -> ch_err=4'b0010, fail_cnt=1.
- Only three channels written, then PASS -> fail_cnt increments, ch_seen=4'b1011.
- Two writes to a (0x1, then 0x2) one cycle apart, reg_val_i=0x2 -> no error; PASS issued 1 cycle after the second write -> EVAL waits until that compare completes.
- Tag held at AB61 for 10 cycles -> only one count; DONE_TAG -> done_o=1 sticky; reset asserted mid-ARMED -> all outputs 0 asynchronously.
- With CHK_TIMEOUT_EN and TIMEOUT_CYC=100: START, no PASS -> timeout_o=1 at cycle 100, fail_cnt=1, done_o=1.
